// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: FSM states,
// opcode/funct fields, ALU operation codes and the internal ALU-op selector.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTEXEC   = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } mc_state_t;

    // 2'b11 is unused and decodes as an invalid operation
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLLV = 4'b1011;
    localparam logic [3:0] ALU_SRLV = 4'b1100;
    localparam logic [3:0] ALU_SRAV = 4'b1101;

    // Terminal states of an instruction (raise instr_done and return to FETCH)
    function automatic logic is_done_state(input mc_state_t st);
        logic done;
        case (st)
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: done = 1'b1;
            default:                                              done = 1'b0;
        endcase
        return done;
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU-control decode: (aluop, funct) -> alucontrl, with a flag
// telling the FSM whether an R-type funct field is one we implement.
module mips_alu_decoder
    import mips_pkg::*;
#(
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  aluop_t                    aluop,
    input  logic [5:0]                funct,
    output logic [ALU_CTRL_WIDTH-1:0] alucontrl,
    output logic                      funct_valid
);

    logic [3:0] code_s;

    // Map the ALU-op selector and funct field to a 4-bit operation code
    always_comb begin
        code_s      = ALU_ADD;
        funct_valid = 1'b1;
        case (aluop)
            ALUOP_ADD: code_s = ALU_ADD;
            ALUOP_SUB: code_s = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_SLL:  code_s = ALU_SLL;
                    FN_SRL:  code_s = ALU_SRL;
                    FN_SRA:  code_s = ALU_SRA;
                    FN_SLLV: code_s = ALU_SLLV;
                    FN_SRLV: code_s = ALU_SRLV;
                    FN_SRAV: code_s = ALU_SRAV;
                    FN_ADD:  code_s = ALU_ADD;
                    FN_SUB:  code_s = ALU_SUB;
                    FN_AND:  code_s = ALU_AND;
                    FN_OR:   code_s = ALU_OR;
                    FN_XOR:  code_s = ALU_XOR;
                    FN_NOR:  code_s = ALU_NOR;
                    FN_SLT:  code_s = ALU_SLT;
                    default: begin
                        code_s      = ALU_ADD;
                        funct_valid = 1'b0;
                    end
                endcase
            end
            default: begin
                code_s      = ALU_ADD;
                funct_valid = 1'b0;
            end
        endcase
    end

    assign alucontrl = ALU_CTRL_WIDTH'(code_s);

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM driving the shared datapath.
// Define MIPS_MC_BNE_EN to accept BNE (opcode 000101); otherwise it traps.
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter int INSTR_WIDTH    = 32,
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [INSTR_WIDTH-1:0]    instr,
    input  logic                      zero,
    output logic                      iord,
    output logic                      memwrite,
    output logic                      irwrite,
    output logic                      regdst,
    output logic                      memtoreg,
    output logic                      regwrite,
    output logic                      alusrca,
    output logic [1:0]                alusrcb,
    output logic [1:0]                pcsrc,
    output logic                      pcen,
    output logic [ALU_CTRL_WIDTH-1:0] alucontrl,
    output logic                      instr_done,
    output logic                      illegal_op
);

    mc_state_t                 state_q;
    mc_state_t                 state_d;
    logic [5:0]                opcode_s;
    logic [5:0]                funct_s;
    logic                      instr_unused_s;
    aluop_t                    aluop_s;
    logic [ALU_CTRL_WIDTH-1:0] alu_code_s;
    logic                      funct_valid_s;

    logic       iord_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       regdst_s;
    logic       memtoreg_s;
    logic       regwrite_s;
    logic       alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] pcsrc_s;
    logic       pcwrite_s;
    logic       branch_s;
    logic       branch_taken_s;
    logic       pcen_s;
    logic       done_s;
    logic       illegal_s;

    assign opcode_s       = instr[INSTR_WIDTH-1 -: 6];
    assign funct_s        = instr[5:0];
    assign instr_unused_s = ^instr[INSTR_WIDTH-7:6];

    mips_alu_decoder #(
        .ALU_CTRL_WIDTH (ALU_CTRL_WIDTH)
    ) u_alu_decoder (
        .aluop       (aluop_s),
        .funct       (funct_s),
        .alucontrl   (alu_code_s),
        .funct_valid (funct_valid_s)
    );

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and per-state raw control values
    always_comb begin
        state_d        = state_q;
        iord_s         = 1'b0;
        memwrite_s     = 1'b0;
        irwrite_s      = 1'b0;
        regdst_s       = 1'b0;
        memtoreg_s     = 1'b0;
        regwrite_s     = 1'b0;
        alusrca_s      = 1'b0;
        alusrcb_s      = 2'b00;
        pcsrc_s        = 2'b00;
        pcwrite_s      = 1'b0;
        branch_s       = 1'b0;
        branch_taken_s = 1'b0;
        aluop_s        = ALUOP_ADD;
        illegal_s      = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite_s = 1'b1;
                alusrcb_s = 2'b01;
                pcsrc_s   = 2'b00;
                pcwrite_s = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alusrcb_s = 2'b11;
                case (opcode_s)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEXEC;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                case (opcode_s)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEMRD: begin
                iord_s  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_RTEXEC: begin
                alusrca_s = 1'b1;
                aluop_s   = ALUOP_FUNCT;
                if (funct_valid_s) begin
                    state_d = S_ALUWB;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_s = 1'b1;
                aluop_s   = ALUOP_SUB;
                pcsrc_s   = 2'b01;
                branch_s  = 1'b1;
`ifdef MIPS_MC_BNE_EN
                if (opcode_s == OP_BNE) begin
                    branch_taken_s = ~zero;
                end else begin
                    branch_taken_s = zero;
                end
`else
                branch_taken_s = zero;
`endif
                state_d = S_FETCH;
            end
            S_ADDIEXEC: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                illegal_s = 1'b1;
                state_d   = S_TRAP;
            end
            default: begin
                illegal_s = 1'b1;
                state_d   = S_TRAP;
            end
        endcase
    end

    assign pcen_s = pcwrite_s | (branch_s & branch_taken_s);
    assign done_s = is_done_state(state_q);

    // Hold every control at zero while reset is asserted so nothing writes
    always_comb begin
        if (!rst_n) begin
            iord       = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            pcsrc      = 2'b00;
            pcen       = 1'b0;
            alucontrl  = '0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end else begin
            iord       = iord_s;
            memwrite   = memwrite_s;
            irwrite    = irwrite_s;
            regdst     = regdst_s;
            memtoreg   = memtoreg_s;
            regwrite   = regwrite_s;
            alusrca    = alusrca_s;
            alusrcb    = alusrcb_s;
            pcsrc      = pcsrc_s;
            pcen       = pcen_s;
            alucontrl  = alu_code_s;
            instr_done = done_s;
            illegal_op = illegal_s;
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: each cycle's stimulus and expected
// controls are queued together, then replayed and compared cycle by cycle.
module tb_mips_mc_controller;

    typedef enum int {
        T_RESET, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
        T_RTEXEC, T_ALUWB, T_BRANCH, T_ADDIEXEC, T_ADDIWB, T_JUMP, T_TRAP
    } tb_st_e;

    typedef struct {
        logic        rst_v;
        logic [31:0] ins;
        logic        zr;
        logic [13:0] ec;
        logic        care;
        logic [3:0]  ea;
    } sb_t;

    localparam int B_IORD = 13, B_MW = 12, B_IRW = 11, B_RDST = 10, B_M2R = 9;
    localparam int B_RW = 8, B_SRCA = 7, B_PCEN = 2, B_DONE = 1, B_ILL = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic        pcen, instr_done, illegal_op;
    logic [3:0]  alucontrl;
    logic [13:0] ctrl_obs;

    int checks   = 0;
    int failures = 0;

    sb_t         sb_q[$];
    logic [31:0] cur_ins;
    logic        cur_zero;
    logic        cur_taken;
    logic [3:0]  cur_code;

    always #5 clk = ~clk;

    mips_mc_controller #(
        .INSTR_WIDTH    (32),
        .ALU_CTRL_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrl  (alucontrl),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    assign ctrl_obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                       alusrcb, pcsrc, pcen, instr_done, illegal_op};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference control table for each state
    function automatic void spec_out(input tb_st_e st, input logic taken, input logic [3:0] rt_code,
                                     output logic [13:0] c, output logic care, output logic [3:0] a);
        c    = 14'd0;
        care = 1'b0;
        a    = 4'd0;
        case (st)
            T_RESET:    begin care = 1'b1; a = 4'b0000; end
            T_FETCH:    begin c[B_IRW] = 1'b1; c[6:5] = 2'b01; c[B_PCEN] = 1'b1; care = 1'b1; a = 4'b0010; end
            T_DECODE:   begin c[6:5] = 2'b11; care = 1'b1; a = 4'b0010; end
            T_MEMADR:   begin c[B_SRCA] = 1'b1; c[6:5] = 2'b10; care = 1'b1; a = 4'b0010; end
            T_MEMRD:    begin c[B_IORD] = 1'b1; end
            T_MEMWB:    begin c[B_RW] = 1'b1; c[B_M2R] = 1'b1; c[B_DONE] = 1'b1; end
            T_MEMWR:    begin c[B_IORD] = 1'b1; c[B_MW] = 1'b1; c[B_DONE] = 1'b1; end
            T_RTEXEC:   begin c[B_SRCA] = 1'b1; care = 1'b1; a = rt_code; end
            T_ALUWB:    begin c[B_RDST] = 1'b1; c[B_RW] = 1'b1; c[B_DONE] = 1'b1; end
            T_BRANCH:   begin c[B_SRCA] = 1'b1; c[4:3] = 2'b01; c[B_PCEN] = taken; c[B_DONE] = 1'b1;
                              care = 1'b1; a = 4'b0110; end
            T_ADDIEXEC: begin c[B_SRCA] = 1'b1; c[6:5] = 2'b10; care = 1'b1; a = 4'b0010; end
            T_ADDIWB:   begin c[B_RW] = 1'b1; c[B_DONE] = 1'b1; end
            T_JUMP:     begin c[4:3] = 2'b10; c[B_PCEN] = 1'b1; c[B_DONE] = 1'b1; end
            T_TRAP:     begin c[B_ILL] = 1'b1; end
            default:    begin c = 14'd0; end
        endcase
    endfunction

    task automatic p(input tb_st_e st);
        sb_t e;
        e.rst_v = (st != T_RESET);
        e.ins   = cur_ins;
        e.zr    = cur_zero;
        spec_out(st, cur_taken, cur_code, e.ec, e.care, e.ea);
        sb_q.push_back(e);
    endtask

    task automatic setup(input logic [31:0] ins, input logic zr, input logic taken, input logic [3:0] code);
        cur_ins   = ins;
        cur_zero  = zr;
        cur_taken = taken;
        cur_code  = code;
    endtask

    task automatic drain(input string tag);
        sb_t e;
        int  cyc;
        cyc = 1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            rst_n = e.rst_v;
            instr = e.ins;
            zero  = e.zr;
            #1;
            check_eq($sformatf("%s.c%0d.ctrl", tag, cyc), 32'(ctrl_obs), 32'(e.ec));
            if (e.care) begin
                check_eq($sformatf("%s.c%0d.alu", tag, cyc), 32'(alucontrl), 32'(e.ea));
            end
            cyc++;
        end
    endtask

    logic [5:0] fn_tab   [12] = '{6'h20, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                  6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [3:0] code_tab [12] = '{4'b0010, 4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0111,
                                  4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101};

    initial begin
        rst_n = 1'b0;
        instr = 32'd0;
        zero  = 1'b0;

        setup(32'h8C080004, 1'b0, 1'b0, 4'd0);
        p(T_RESET); p(T_RESET);
        drain("RESET");

        p(T_FETCH); p(T_DECODE); p(T_MEMADR); p(T_MEMRD); p(T_MEMWB);
        drain("LW");

        setup(32'h01095022, 1'b0, 1'b0, 4'b0110);
        p(T_FETCH); p(T_DECODE); p(T_RTEXEC); p(T_ALUWB);
        drain("SUB");

        for (int i = 0; i < 12; i++) begin
            setup(32'h01095000 | 32'(fn_tab[i]), 1'b0, 1'b0, code_tab[i]);
            p(T_FETCH); p(T_DECODE); p(T_RTEXEC); p(T_ALUWB);
            drain($sformatf("RT_%02h", fn_tab[i]));
        end

        setup(32'h11090002, 1'b1, 1'b1, 4'd0);
        p(T_FETCH); p(T_DECODE); p(T_BRANCH);
        drain("BEQ_T");
        setup(32'h11090002, 1'b0, 1'b0, 4'd0);
        p(T_FETCH); p(T_DECODE); p(T_BRANCH);
        drain("BEQ_NT");

        setup(32'h21080005, 1'b0, 1'b0, 4'd0);
        p(T_FETCH); p(T_DECODE); p(T_ADDIEXEC); p(T_ADDIWB);
        drain("ADDI");

        setup(32'h08000010, 1'b1, 1'b0, 4'd0);
        p(T_FETCH); p(T_DECODE); p(T_JUMP);
        drain("J");

        setup(32'hAC080004, 1'b0, 1'b0, 4'd0);
        p(T_FETCH); p(T_DECODE); p(T_MEMADR); p(T_MEMWR);
        drain("SW");

        setup(32'h0109503F, 1'b0, 1'b0, 4'b0010);
        p(T_FETCH); p(T_DECODE); p(T_RTEXEC); p(T_TRAP); p(T_TRAP); p(T_RESET);
        drain("BADFN");

        setup(32'hFC000000, 1'b0, 1'b0, 4'd0);
        p(T_FETCH); p(T_DECODE);
        for (int i = 0; i < 10; i++) p(T_TRAP);
        p(T_RESET);
        drain("BADOP");

        setup(32'hAC080004, 1'b0, 1'b0, 4'd0);
        p(T_FETCH); p(T_DECODE); p(T_MEMADR); p(T_RESET); p(T_FETCH); p(T_DECODE);
        drain("SW_RST");
        setup(32'hAC080004, 1'b0, 1'b0, 4'd0);
        p(T_RESET);
        drain("SW_RST2");

        setup(32'h15090002, 1'b0, 1'b1, 4'd0);
`ifdef MIPS_MC_BNE_EN
        p(T_FETCH); p(T_DECODE); p(T_BRANCH);
`else
        p(T_FETCH); p(T_DECODE); p(T_TRAP); p(T_TRAP); p(T_RESET);
`endif
        drain("BNE");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
